phy_tx_lane_serializer: RTL and testbench
=========================================

// Module: phy_tx_lane_serializer
// PURPOSE
//  Single-lane PHY transmit serializer, the send-side counterpart of the per-lane serial-to-parallel receiver.
//  Buffers bytes from the byte-striping stage in a 2-entry FIFO and emits 8-bit symbols MSB-first on a 1-bit line.
//  After reset it sends TRAIN_COUNT COM symbols so the receiver can align, then sends data or IDLE symbols.
//  Runs entirely on clk_8f, so one symbol takes 8 cycles.
// PARAMETERS
//  TRAIN_COUNT  4      number of COM symbols sent after reset before entering ACTIVE
//  COM_SYM      8'hBC  alignment (COM) symbol
//  IDLE_SYM     8'hBC  symbol sent in ACTIVE when the FIFO is empty; the receiver treats it as invalid
// PORTS
//  clk_8f       in   1  bit clock; the only clock in this block
//  reset        in   1  synchronous, active-low reset
//  data_in      in   8  byte to transmit
//  valid_in     in   1  data_in is valid; a byte is accepted on a posedge where valid_in && ready_out
//  ready_out    out  1  a FIFO slot is free
//  data_out     out  1  serial line, MSB first
//  sym_start    out  1  high in the cycle data_out carries bit 7 of a symbol
//  active_out   out  1  training is complete (state ACTIVE)
//  com_err      out  1  1-cycle pulse: an accepted valid byte equals COM_SYM
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - data_out, sym_start, active_out, com_err and ready_out all go to 0.
//   - The FIFO is flushed, bit_cnt is set to 7, the training counter is cleared and the state becomes TRAIN.
//   - Reset mid-symbol abandons the partial symbol. Training restarts from 0 once reset is released.
//  States:
//   - TRAIN -> ACTIVE after the TRAIN_COUNT-th COM symbol has been loaded.
//   - ACTIVE is left only through reset.
//  Symbol timing:
//   - bit_cnt counts 0..7 and wraps.
//   - The edge where bit_cnt==7 is a load edge: the next symbol is selected and loaded, and bit_cnt goes to 0.
//   - The cycle after a load edge: data_out = symbol bit 7 and sym_start = 1.
//   - The following 7 cycles carry bits 6..0.
//   - The first out-of-reset edge is a load edge, because bit_cnt resets to 7.
//  Symbol select at a load edge:
//   - TRAIN: COM_SYM, and the training counter increments.
//   - ACTIVE, FIFO non-empty: the FIFO head, which is popped at that edge.
//   - ACTIVE, FIFO empty: IDLE_SYM.
//  active_out rises in the same cycle as sym_start of the first ACTIVE symbol.
//  The FIFO never pops during TRAIN; bytes accepted during TRAIN are sent first once ACTIVE begins, in order.
//  ready_out:
//   - ready_out = (occupancy < 2) in every cycle outside reset, including TRAIN.
//   - It depends only on current occupancy, with no combinational path from the pop.
//   - Push while full: ignored, and the byte is not accepted.
//   - Push and pop on the same edge with occupancy 1: occupancy stays 1 and order is kept.
//  Latency: a byte pushed into an empty FIFO in ACTIVE starts on data_out 1..8 cycles later (next load edge + 1).
//  com_err is registered: high in the cycle after accepting a valid byte equal to COM_SYM. The byte is still queued and sent.
//  Back-to-back pushes at one per cycle are accepted until the FIFO is full; afterwards throughput is 1 byte per 8 cycles.
// STRUCTURE
//  Shared header phy_defs.vh: COM/IDLE symbol constants, SYM_W=8, and the TRAIN/ACTIVE state encodings.
//  The RX side includes the same header.
//  Sub-module phy_tx_fifo2: 2-entry, 8-bit synchronous FIFO with push/pop/full/empty and the same reset.
//  Top level: bit_cnt, training counter, state register, symbol shift register, and output flops.
// TESTING
//  1. Release reset with valid_in=0.
//     -> data_out = 10111100 four times, with sym_start at cycles 1, 9, 17 and 25.
//     -> active_out rises at cycle 33, followed by continuous 0xBC.
//  2. Push 0xA5 at cycle 3 (during TRAIN).
//     -> ready_out stays 1.
//     -> The first ACTIVE symbol (sym_start at cycle 33) is 10100101, followed by IDLE 0xBC.
//  3. In ACTIVE, hold valid_in with 0x01, 0x02, 0x03.
//     -> 0x01 and 0x02 are accepted and ready_out drops to 0.
//     -> 0x03 is accepted after the first pop.
//     -> Symbols 0x01, 0x02 and 0x03 are sent contiguously.
//  4. Push a valid 0xBC in ACTIVE.
//     -> com_err = 1 for exactly one cycle after acceptance.
//     -> 0xBC is still transmitted in its slot.
//  5. Assert reset while bit 3 of 0x5A is on the line and the FIFO holds 0x11.
//     -> Next cycle: data_out, active_out, ready_out = 0.
//     -> After release: 4 COM symbols; 0x11 is never sent.
//  6. FIFO full, push on a load edge.
//     -> Not accepted; ready_out = 1 the next cycle.
//     -> The re-presented byte is accepted and sent after the queued byte.

Source files
------------

// File: rtl/phy_tx_lane_serializer_pkg.sv
// Shared constants and types for the single-lane PHY transmit serializer.
// The RX lane deserializer imports the same symbol definitions.
package phy_tx_lane_serializer_pkg;

  localparam int unsigned SYM_W           = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned FIFO_CNT_W      = 2;
  localparam int unsigned DEF_TRAIN_COUNT = 4;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t DEF_COM_SYM  = 8'hBC;
  localparam sym_t DEF_IDLE_SYM = 8'hBC;

  typedef enum logic {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/phy_tx_lane_serializer_fifo2.sv
// Two-entry synchronous byte FIFO feeding the lane serializer.
// Flags decode the occupancy register; full_next_c_o previews occupancy after this edge.
module phy_tx_lane_serializer_fifo2
  import phy_tx_lane_serializer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  sym_t wdata_i,
  output sym_t rdata_c_o,
  output logic empty_c_o,
  output logic full_next_c_o
);

  sym_t                  mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                  full_c, do_push, do_pop;

  always_comb begin
    full_c        = (cnt_q == FIFO_CNT_W'(2));
    empty_c_o     = (cnt_q == '0);
    do_push       = push_i && !full_c;
    do_pop        = pop_i && !empty_c_o;
    wr_ptr_d      = wr_ptr_q ^ do_push;
    rd_ptr_d      = rd_ptr_q ^ do_pop;
    cnt_d         = cnt_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    full_next_c_o = (cnt_d == FIFO_CNT_W'(2));
    rdata_c_o     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Single-lane PHY TX serializer: trains with COM symbols after reset, then
// sends queued bytes (or IDLE) MSB-first, one symbol every 8 clk_8f cycles.
module phy_tx_lane_serializer
  import phy_tx_lane_serializer_pkg::*;
#(
  parameter int unsigned TRAIN_COUNT = DEF_TRAIN_COUNT,
  parameter sym_t        COM_SYM     = DEF_COM_SYM,
  parameter sym_t        IDLE_SYM    = DEF_IDLE_SYM
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [SYM_W-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             sym_start,
  output logic             active_out,
  output logic             com_err
);

  localparam int unsigned TRAIN_CNT_W = $clog2(TRAIN_COUNT + 1);
  localparam logic [TRAIN_CNT_W-1:0] TRAIN_LAST = TRAIN_CNT_W'(TRAIN_COUNT - 1);
  localparam logic [BIT_CNT_W-1:0]   LOAD_CNT   = BIT_CNT_W'(SYM_W - 1);

  tx_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TRAIN_CNT_W-1:0] train_cnt_q, train_cnt_d;
  sym_t                   shift_q, shift_d;
  logic                   data_out_q, data_out_d;
  logic                   sym_start_q, sym_start_d;
  logic                   active_q, active_d;
  logic                   com_err_q, com_err_d;
  logic                   ready_q, ready_d;
  logic                   load_c, push_c, pop_c;
  sym_t                   sym_c, fifo_head_c;
  logic                   fifo_empty_c, fifo_full_next_c;

  phy_tx_lane_serializer_fifo2 u_fifo (
    .clk_i         (clk_8f),
    .rst_ni        (reset),
    .push_i        (push_c),
    .pop_i         (pop_c),
    .wdata_i       (data_in),
    .rdata_c_o     (fifo_head_c),
    .empty_c_o     (fifo_empty_c),
    .full_next_c_o (fifo_full_next_c)
  );

  // Symbol scheduling: shift out between load edges, pick the next symbol on a load edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
    train_cnt_d = train_cnt_q;
    shift_d     = {shift_q[SYM_W-2:0], 1'b0};
    data_out_d  = shift_q[SYM_W-1];
    sym_start_d = 1'b0;
    active_d    = active_q;
    pop_c       = 1'b0;
    sym_c       = IDLE_SYM;
    load_c      = (bit_cnt_q == LOAD_CNT);
    push_c      = valid_in && ready_q;
    com_err_d   = push_c && (data_in == COM_SYM);

    if (load_c) begin
      unique case (state_q)
        ST_TRAIN: begin
          sym_c       = COM_SYM;
          train_cnt_d = train_cnt_q + TRAIN_CNT_W'(1);
          if (train_cnt_q == TRAIN_LAST) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          active_d = 1'b1;
          if (!fifo_empty_c) begin
            sym_c = fifo_head_c;
            pop_c = 1'b1;
          end
        end
        default: state_d = ST_TRAIN;
      endcase
      shift_d     = {sym_c[SYM_W-2:0], 1'b0};
      data_out_d  = sym_c[SYM_W-1];
      sym_start_d = 1'b1;
    end

    // Registered from next occupancy, so there is no combinational path from pop.
    ready_d = !fifo_full_next_c;
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state_q     <= ST_TRAIN;
      bit_cnt_q   <= LOAD_CNT;
      train_cnt_q <= '0;
      shift_q     <= '0;
      data_out_q  <= 1'b0;
      sym_start_q <= 1'b0;
      active_q    <= 1'b0;
      com_err_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      train_cnt_q <= train_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      sym_start_q <= sym_start_d;
      active_q    <= active_d;
      com_err_q   <= com_err_d;
      ready_q     <= ready_d;
    end
  end

  assign data_out   = data_out_q;
  assign sym_start  = sym_start_q;
  assign active_out = active_q;
  assign com_err    = com_err_q;
  assign ready_out  = ready_q;

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed bench for phy_tx_lane_serializer: training, queueing, COM error,
// mid-symbol reset and full-FIFO push, with a serial-line symbol monitor.
module tb_phy_tx_lane_serializer;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, sym_start, active_out, com_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sym_q [$];
  int         cyc_q [$];
  logic       act_q [$];

  int         nbits = 0;
  logic [7:0] sh;
  int         st_cyc;
  logic       st_act;

  phy_tx_lane_serializer dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .sym_start  (sym_start),
    .active_out (active_out),
    .com_err    (com_err)
  );

  always #5 clk_8f = ~clk_8f;

  // Reassemble serial symbols on the falling edge; a reset drops any partial symbol.
  always @(negedge clk_8f) begin
    if (!reset) begin
      nbits = 0;
    end else if (sym_start) begin
      sh     = {7'b0, data_out};
      nbits  = 1;
      st_cyc = cyc;
      st_act = active_out;
    end else if (nbits > 0) begin
      sh    = {sh[6:0], data_out};
      nbits = nbits + 1;
    end
    if (nbits == 8) begin
      sym_q.push_back(sh);
      cyc_q.push_back(st_cyc);
      act_q.push_back(st_act);
      nbits = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_8f);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset(input bit chk);
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) tick();
    if (chk) begin
      check("rst_data_out",   32'(data_out),   0);
      check("rst_sym_start",  32'(sym_start),  0);
      check("rst_active_out", 32'(active_out), 0);
      check("rst_com_err",    32'(com_err),    0);
      check("rst_ready_out",  32'(ready_out),  0);
    end
    sym_q.delete();
    cyc_q.delete();
    act_q.delete();
    reset = 1'b1;
    cyc   = 0;
    tick();
  endtask

  task automatic wait_syms(input string tag, input int n);
    int k = 0;
    while (sym_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_nsym"}, 32'(sym_q.size() >= n), 1);
  endtask

  task automatic exp_sym(input string tag, input int idx, input logic [7:0] s, input int c);
    check($sformatf("%s_sym%0d", tag, idx), 32'(sym_q[idx]), 32'(s));
    check($sformatf("%s_cyc%0d", tag, idx), 32'(cyc_q[idx]), 32'(c));
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // 1: training pattern then continuous IDLE
    do_reset(1'b1);
    check("t1_start_c1", 32'(sym_start), 1);
    check("t1_ready_c1", 32'(ready_out), 1);
    check("t1_bit7_c1",  32'(data_out),  1);
    wait_syms("t1", 6);
    for (int i = 0; i < 6; i++) begin
      exp_sym("t1", i, 8'hBC, 1 + 8 * i);
      check($sformatf("t1_act%0d", i), 32'(act_q[i]), 32'(i >= 4));
    end

    // 2: byte pushed during TRAIN goes out first in ACTIVE
    do_reset(1'b0);
    run_to(2);
    valid_in = 1'b1;
    data_in  = 8'hA5;
    check("t2_ready_c2", 32'(ready_out), 1);
    tick();
    valid_in = 1'b0;
    check("t2_ready_c3", 32'(ready_out), 1);
    run_to(32);
    check("t2_ready_c32",  32'(ready_out),  1);
    check("t2_active_c32", 32'(active_out), 0);
    wait_syms("t2", 6);
    exp_sym("t2", 3, 8'hBC, 25);
    exp_sym("t2", 4, 8'hA5, 33);
    check("t2_act4", 32'(act_q[4]), 1);
    exp_sym("t2", 5, 8'hBC, 41);

    // 3: held valid with 01,02,03 fills the FIFO, then 03 enters after a pop
    do_reset(1'b0);
    run_to(34);
    valid_in = 1'b1;
    data_in  = 8'h01;
    tick();
    check("t3_ready_c35", 32'(ready_out), 1);
    data_in = 8'h02;
    tick();
    check("t3_ready_c36", 32'(ready_out), 0);
    data_in = 8'h03;
    run_to(40);
    check("t3_ready_c40", 32'(ready_out), 0);
    tick();
    check("t3_ready_c41", 32'(ready_out), 1);
    tick();
    check("t3_ready_c42", 32'(ready_out), 0);
    valid_in = 1'b0;
    wait_syms("t3", 9);
    exp_sym("t3", 4, 8'hBC, 33);
    exp_sym("t3", 5, 8'h01, 41);
    exp_sym("t3", 6, 8'h02, 49);
    exp_sym("t3", 7, 8'h03, 57);
    exp_sym("t3", 8, 8'hBC, 65);

    // 4: COM byte flags com_err for one cycle and is still sent
    do_reset(1'b0);
    run_to(34);
    check("t4_comerr_c34", 32'(com_err), 0);
    valid_in = 1'b1;
    data_in  = 8'hBC;
    tick();
    check("t4_comerr_c35", 32'(com_err), 1);
    data_in = 8'hA5;
    tick();
    check("t4_comerr_c36", 32'(com_err), 0);
    valid_in = 1'b0;
    tick();
    check("t4_comerr_c37", 32'(com_err), 0);
    wait_syms("t4", 7);
    exp_sym("t4", 5, 8'hBC, 41);
    exp_sym("t4", 6, 8'hA5, 49);

    // 5: reset mid-symbol with a byte queued
    do_reset(1'b0);
    run_to(34);
    valid_in = 1'b1;
    data_in  = 8'h5A;
    tick();
    valid_in = 1'b0;
    run_to(41);
    check("t5_start_c41", 32'(sym_start), 1);
    valid_in = 1'b1;
    data_in  = 8'h11;
    tick();
    valid_in = 1'b0;
    run_to(45);
    check("t5_bit3_c45", 32'(data_out), 1);
    reset = 1'b0;
    tick();
    check("t5_data_out_rst",   32'(data_out),   0);
    check("t5_active_out_rst", 32'(active_out), 0);
    check("t5_ready_out_rst",  32'(ready_out),  0);
    check("t5_sym_start_rst",  32'(sym_start),  0);
    do_reset(1'b0);
    wait_syms("t5", 6);
    for (int i = 0; i < 6; i++) exp_sym("t5", i, 8'hBC, 1 + 8 * i);

    // 6: push on a load edge while full is refused, then re-presented byte lands
    do_reset(1'b0);
    run_to(34);
    valid_in = 1'b1;
    data_in  = 8'hC1;
    tick();
    data_in = 8'hC2;
    tick();
    valid_in = 1'b0;
    run_to(40);
    valid_in = 1'b1;
    data_in  = 8'hC3;
    check("t6_ready_c40", 32'(ready_out), 0);
    tick();
    check("t6_ready_c41", 32'(ready_out), 1);
    tick();
    check("t6_ready_c42", 32'(ready_out), 0);
    valid_in = 1'b0;
    wait_syms("t6", 9);
    exp_sym("t6", 5, 8'hC1, 41);
    exp_sym("t6", 6, 8'hC2, 49);
    exp_sym("t6", 7, 8'hC3, 57);
    exp_sym("t6", 8, 8'hBC, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
